// File: rtl/img_writer.sv
// img_writer: Avalon-MM slave that turns software-pushed pixels into a
// VGA-style stream (RGB, active-low HSYNC/VSYNC, frame_start) with its own
// sync timing. A small FIFO decouples bus writes from the pixel clock.
module img_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] writedata,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  input  logic        address,
  output logic [23:0] readdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_S  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_E  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_S  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_E  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C  = 12'(V_TOTAL - 1);
  localparam logic [7:0]  DEPTH_C   = 8'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_LAST_C = AW'(FIFO_DEPTH - 1);

  // Pixel storage and FIFO bookkeeping
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [7:0]    level_q, level_d;

  // Control/status and raster position
  logic        enable_q, enable_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;

  // Registered video outputs
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frameStart_q, frameStart_d;

  // Decoded bus strobes and per-cycle datapath conditions
  logic        busWr, pushReq, ctrlWr, stopReq, flagClr;
  logic        run, active, fifoEmpty, fifoFull, pop, push, flush;
  logic [23:0] headPixel;

  assign busWr     = chipselect & write;
  assign pushReq   = busWr & ~address;
  assign ctrlWr    = busWr & address;
  // A control write with bit0 clear stops the raster in this very cycle.
  assign stopReq   = ctrlWr & ~writedata[0];
  assign flagClr   = ctrlWr & writedata[1];
  assign run       = enable_q & ~stopReq;
  assign active    = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
  assign fifoEmpty = (level_q == 8'd0);
  assign fifoFull  = (level_q == DEPTH_C);
  assign pop       = run & active & ~fifoEmpty;
  // When full, a push only fits if the same cycle frees a slot.
  assign push      = pushReq & (~fifoFull | pop);
  // Only the enabled->disabled transition flushes, so a prefill survives.
  assign flush     = enable_q & stopReq;
  assign headPixel = mem_q[rdPtr_q];

  // Next-state logic for FIFO, flags, raster counters and video outputs
  always_comb begin
    enable_d     = ctrlWr ? writedata[0] : enable_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    level_d      = level_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    rgb_d        = 24'd0;
    hsync_d      = 1'b1;
    vsync_d      = 1'b1;
    frameStart_d = 1'b0;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = 8'd0;
    end else begin
      if (push) begin
        wrPtr_d = (wrPtr_q == PTR_LAST_C) ? '0 : wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_d = (rdPtr_q == PTR_LAST_C) ? '0 : rdPtr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 8'd1;
        2'b01:   level_d = level_q - 8'd1;
        default: level_d = level_q;
      endcase
    end

    overflow_d  = (overflow_q & ~flagClr) | (pushReq & fifoFull & ~pop);
    underflow_d = (underflow_q & ~flagClr) | (run & active & fifoEmpty);

    if (!run) begin
      hcnt_d = 12'd0;
      vcnt_d = 12'd0;
    end else begin
      if (hcnt_q == H_LAST_C) begin
        hcnt_d = 12'd0;
        vcnt_d = (vcnt_q == V_LAST_C) ? 12'd0 : vcnt_q + 12'd1;
      end else begin
        hcnt_d = hcnt_q + 12'd1;
      end
      rgb_d        = (active && !fifoEmpty) ? headPixel : 24'd0;
      hsync_d      = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
      vsync_d      = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
      frameStart_d = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= 8'd0;
      enable_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      hcnt_q       <= 12'd0;
      vcnt_q       <= 12'd0;
      rgb_q        <= 24'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      level_q      <= level_d;
      enable_q     <= enable_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frameStart_q <= frameStart_d;
    end
  end

  // FIFO storage write port; contents need no reset since level gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= writedata;
    end
  end

  // Zero-wait-state read mux for status and raster position
  always_comb begin
    readdata = 24'd0;
    if (chipselect && read) begin
      if (address) begin
        readdata = {vcnt_q, hcnt_q};
      end else begin
        readdata = {13'd0, overflow_q, underflow_q, enable_q, level_q};
      end
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_img_writer.sv
// tb_img_writer: directed bench for img_writer with a frame-position/queue
// model checked against the DUT every cycle, plus hand-computed literals.
module tb_img_writer;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int DEPTH = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] writedata = 24'd0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        chipselect = 1'b0;
  logic        address = 1'b0;
  logic [23:0] readdata;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        HSYNC, VSYNC, frame_start;

  int errors = 0;
  int checks = 0;

  img_writer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .writedata(writedata), .write(write),
    .read(read), .chipselect(chipselect), .address(address),
    .readdata(readdata), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Compare one value and report a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: linear position in the frame and a pixel queue
  int          mPos = 0;
  logic        mEn = 1'b0, mOvf = 1'b0, mUdf = 1'b0;
  logic [23:0] mQ[$];
  logic [23:0] expRgb = 24'd0;
  logic        expHs = 1'b1, expVs = 1'b1, expFs = 1'b0;
  int          mH, mV;
  logic        mWr, mCtrl, mPush, mStop, mRunning, mActive;

  task automatic modelReset();
    mPos = 0; mEn = 1'b0; mOvf = 1'b0; mUdf = 1'b0;
    mQ.delete();
    expRgb = 24'd0; expHs = 1'b1; expVs = 1'b1; expFs = 1'b0;
  endtask

  task automatic modelStep();
    mWr      = chipselect && write;
    mCtrl    = mWr && address;
    mPush    = mWr && !address;
    mStop    = mCtrl && !writedata[0];
    mRunning = mEn && !mStop;
    mH       = mPos % HT;
    mV       = mPos / HT;
    mActive  = (mH < HA) && (mV < VA);
    if (mCtrl && writedata[1]) begin
      mOvf = 1'b0;
      mUdf = 1'b0;
    end
    if (mRunning) begin
      if (mActive && mQ.size() > 0) expRgb = mQ.pop_front();
      else expRgb = 24'd0;
      if (mActive && mQ.size() == 0 && expRgb == 24'd0 && !mQ.size()) begin
      end
      expHs = !(mH >= HA + HF && mH < HA + HF + HS);
      expVs = !(mV >= VA + VF && mV < VA + VF + VS);
      expFs = (mPos == 0);
      mPos  = (mPos + 1) % FRAME;
    end else begin
      expRgb = 24'd0; expHs = 1'b1; expVs = 1'b1; expFs = 1'b0;
      mPos = 0;
    end
    if (mPush) begin
      if (mQ.size() < DEPTH) mQ.push_back(writedata);
      else mOvf = 1'b1;
    end
    if (mEn && mStop) mQ.delete();
    if (mCtrl) mEn = writedata[0];
  endtask

  // Underflow is decided from the queue state before this cycle's pop
  logic mWasEmpty;
  task automatic modelCycle();
    mWasEmpty = (mQ.size() == 0);
    if (mEn && !(chipselect && write && address && !writedata[0]) &&
        ((mPos % HT) < HA) && ((mPos / HT) < VA) && mWasEmpty)
      mUdf = 1'b1;
    modelStep();
  endtask

  function automatic logic [23:0] modelReaddata();
    logic [23:0] r;
    r = 24'd0;
    if (chipselect && read) begin
      if (address) r = {12'(mPos / HT), 12'(mPos % HT)};
      else r = {13'd0, mOvf, mUdf, mEn, 8'(mQ.size())};
    end
    return r;
  endfunction

  // Advance the model on each active edge, or reset it asynchronously
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) modelReset();
    else modelCycle();
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    checkOutput("video", {5'd0, VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, frame_start},
                {5'd0, expRgb, expHs, expVs, expFs});
    checkOutput("readdata", {8'd0, readdata}, {8'd0, modelReaddata()});
  end

  // Snapshots taken mid-cycle for the hand-computed checks
  logic [26:0] snapVid;
  logic [23:0] snapRd;

  // Drive one bus cycle starting just after an active edge
  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic addr, input logic [23:0] data);
    chipselect = cs; write = wr; read = rd; address = addr; writedata = data;
    @(negedge clk);
    snapVid = {VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, frame_start};
    snapRd  = readdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();               applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'd0); endtask
  task automatic pushPix(input logic [23:0] d); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, d);  endtask
  task automatic ctrlWrite(input logic [23:0] d); applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, d); endtask
  task automatic readReg(input logic a);     applyStimulus(1'b1, 1'b0, 1'b1, a, 24'd0);    endtask

  int          fsCount;
  int          p;
  logic [23:0] fillVal;
  logic        sawC5;

  // Directed scenarios
  initial begin
    reset_n = 1'b0;
    repeat (3) idleCycle();
    reset_n = 1'b1;
    readReg(1'b0);
    checkOutput("rst_status", {8'd0, snapRd}, 32'h0);
    checkOutput("rst_video", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});

    // Normal frame: prefill four pixels, enable, keep the FIFO fed
    pushPix(24'h111111); pushPix(24'h222222); pushPix(24'h333333); pushPix(24'h444444);
    ctrlWrite(24'h1);
    fsCount = 0;
    fillVal = 24'h500000;
    for (int k = 0; k < 2 * FRAME; k++) begin
      p = k % FRAME;
      if ((p >= 4 && p <= 7) || (p >= 12 && p <= 15)) begin
        pushPix(fillVal);
        fillVal = fillVal + 24'd1;
      end else begin
        idleCycle();
      end
      fsCount += int'(snapVid[0]);
      if (k == 1) checkOutput("nf_pix0", {5'd0, snapVid}, {5'd0, 24'h111111, 3'b111});
      if (k == 4) checkOutput("nf_pix3", {5'd0, snapVid}, {5'd0, 24'h444444, 3'b110});
      if (k == 5) checkOutput("nf_blank4", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
      if (k == 6) checkOutput("nf_hsync5", {5'd0, snapVid}, {5'd0, 24'h0, 3'b010});
      if (k == 7) checkOutput("nf_hsync6", {5'd0, snapVid}, {5'd0, 24'h0, 3'b010});
      if (k == 8) checkOutput("nf_blank7", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
      if (k == 41) checkOutput("nf_fs_frame2", {31'd0, snapVid[0]}, 32'd1);
    end
    checkOutput("nf_fs_count", fsCount, 32'd2);

    // Underflow: only two pixels available for a four-pixel line
    ctrlWrite(24'h2);
    pushPix(24'hAAAAAA); pushPix(24'hBBBBBB);
    ctrlWrite(24'h1);
    for (int k = 0; k < 5; k++) begin
      idleCycle();
      if (k == 1) checkOutput("uf_pix0", {5'd0, snapVid}, {5'd0, 24'hAAAAAA, 3'b111});
      if (k == 2) checkOutput("uf_pix1", {5'd0, snapVid}, {5'd0, 24'hBBBBBB, 3'b110});
      if (k == 3) checkOutput("uf_pix2", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
      if (k == 4) checkOutput("uf_pix3", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
    end
    readReg(1'b0);
    checkOutput("uf_status", {8'd0, snapRd}, 32'h000300);
    ctrlWrite(24'h2);
    readReg(1'b0);
    checkOutput("uf_cleared", {8'd0, snapRd}, 32'h000000);

    // Overflow: five pushes into a four-entry FIFO while disabled
    pushPix(24'hC0C0C1); pushPix(24'hC0C0C2); pushPix(24'hC0C0C3);
    pushPix(24'hC0C0C4); pushPix(24'hC0C0C5);
    readReg(1'b0);
    checkOutput("ovf_status", {8'd0, snapRd}, 32'h000404);
    ctrlWrite(24'h1);
    sawC5 = 1'b0;
    for (int k = 0; k <= FRAME; k++) begin
      idleCycle();
      if (snapVid[26:3] == 24'hC0C0C5) sawC5 = 1'b1;
      if (k == 1) checkOutput("ovf_pix0", {5'd0, snapVid}, {5'd0, 24'hC0C0C1, 3'b111});
      if (k == 4) checkOutput("ovf_pix3", {5'd0, snapVid}, {5'd0, 24'hC0C0C4, 3'b110});
      if (k == 9) checkOutput("ovf_line1", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
    end
    checkOutput("ovf_c5_hidden", {31'd0, sawC5}, 32'd0);
    ctrlWrite(24'h2);

    // Full FIFO with a push in the same cycle as an active pop
    pushPix(24'hD0D0D1); pushPix(24'hD0D0D2); pushPix(24'hD0D0D3); pushPix(24'hD0D0D4);
    ctrlWrite(24'h1);
    pushPix(24'hD0D0D5);
    readReg(1'b0);
    checkOutput("full_status", {8'd0, snapRd}, 32'h000104);
    checkOutput("full_pix0", {5'd0, snapVid}, {5'd0, 24'hD0D0D1, 3'b111});

    // Mid-frame disable at hcnt=2, vcnt=1 (frame position 10)
    repeat (8) idleCycle();
    ctrlWrite(24'h0);
    readReg(1'b1);
    checkOutput("dis_pos", {8'd0, snapRd}, 32'h000000);
    checkOutput("dis_video", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
    readReg(1'b0);
    checkOutput("dis_status", {8'd0, snapRd}, 32'h000200);

    // Re-enable: first visible output is pixel (0,0) with frame_start
    pushPix(24'hE1E1E1);
    ctrlWrite(24'h1);
    idleCycle();
    checkOutput("re_idle", {5'd0, snapVid}, {5'd0, 24'h0, 3'b110});
    idleCycle();
    checkOutput("re_pix0", {5'd0, snapVid}, {5'd0, 24'hE1E1E1, 3'b111});
    pushPix(24'hE2E2E2); pushPix(24'hE3E3E3);
    repeat (3) idleCycle();

    // Asynchronous reset in the middle of a running frame
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 1'b0; writedata = 24'd0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_video", {5'd0, VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, frame_start},
                {5'd0, 24'h0, 3'b110});
    checkOutput("arst_status", {8'd0, readdata}, 32'h000000);
    @(posedge clk);
    #1;
    repeat (2) idleCycle();
    reset_n = 1'b1;
    repeat (3) idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
